// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin sharing of one UART transmitter among NUM_REQ byte producers.
// Latency: valid seen in IDLE -> req_ready strobe next cycle -> transmit pulse the cycle after.
// Backpressure: one byte per grant; no new grant until the UART frame ends (is_transmitting low).
// Optional UART_ARB_LOCK_EN: keep the grant on one requester until it sends a byte with req_last.
module uart_tx_arbiter #(
   parameter int NUM_REQ      = 4,
   parameter int WAIT_TIMEOUT = 16
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic [NUM_REQ-1:0]         req_valid,
   input  logic [8*NUM_REQ-1:0]       req_data,
   input  logic [NUM_REQ-1:0]         req_last,
   output logic [NUM_REQ-1:0]         req_ready,
   output logic [$clog2(NUM_REQ)-1:0] grant_id,
   output logic                       busy,
   output logic                       transmit,
   output logic [7:0]                 tx_byte,
   input  logic                       is_transmitting
);
   localparam int IW = $clog2(NUM_REQ);

   typedef enum logic [2:0] {
      IDLE      = 3'd0,
      LOAD      = 3'd1,
      START     = 3'd2,
      WAIT_BUSY = 3'd3,
      WAIT_DONE = 3'd4
   } state_t;

   state_t             state, state_nxt;
   logic [IW-1:0]      ptr, ptr_nxt;
   logic [IW-1:0]      grant_nxt;
   logic [IW-1:0]      win, idx;
   logic               found;
   logic [7:0]         cnt, cnt_nxt;
   logic [7:0]         byte_nxt;
   logic [NUM_REQ-1:0] ready_nxt;
   logic               transmit_nxt;

`ifdef UART_ARB_LOCK_EN
   logic               locked, locked_nxt;
`else
   // Packet boundaries are meaningless when arbitrating per byte.
   logic               unused_last;
   assign unused_last = ^req_last;
`endif

   // busy is a pure decode of the state register, so it never sees inputs combinationally.
   assign busy = (state != IDLE);

   // Round-robin pick: first valid requester at or after ptr, wrapping modulo NUM_REQ.
   always_comb begin
      found = 1'b0;
      win   = ptr;
      idx   = ptr;
      for (int i = 0; i < NUM_REQ; i++) begin
         idx = ptr + IW'(i);
         if (!found && req_valid[idx]) begin
            found = 1'b1;
            win   = idx;
         end
      end
`ifdef UART_ARB_LOCK_EN
      // While a packet is in flight only its owner may be granted.
      if (locked) begin
         found = req_valid[grant_id];
         win   = grant_id;
      end
`endif
   end

   // Next-state and next-output decode for the grant / load / wait sequence.
   always_comb begin
      state_nxt    = state;
      ptr_nxt      = ptr;
      cnt_nxt      = cnt;
      ready_nxt    = req_ready;
      transmit_nxt = transmit;
      byte_nxt     = tx_byte;
      grant_nxt    = grant_id;
`ifdef UART_ARB_LOCK_EN
      locked_nxt   = locked;
`endif
      case (state)
         IDLE: begin
            // A frame left over from before a reset must finish before the next grant.
            if (!is_transmitting && found) begin
               grant_nxt = win;
               ready_nxt = NUM_REQ'(1) << win;
               state_nxt = LOAD;
            end
         end
         LOAD: begin
            ready_nxt = '0;
            if (req_valid[grant_id]) begin
               byte_nxt     = req_data[{grant_id, 3'b000} +: 8];
               transmit_nxt = 1'b1;
               state_nxt    = START;
`ifdef UART_ARB_LOCK_EN
               locked_nxt   = !req_last[grant_id];
`endif
            end else begin
               // Requester withdrew: nothing sent, ptr stays so it keeps its turn.
               state_nxt = IDLE;
            end
         end
         START: begin
            transmit_nxt = 1'b0;
            cnt_nxt      = 8'd0;
            state_nxt    = WAIT_BUSY;
         end
         WAIT_BUSY: begin
            cnt_nxt = cnt + 8'd1;
            // Exits after WAIT_TIMEOUT cycles here even if the UART never reports busy.
            if (is_transmitting || (cnt == 8'(WAIT_TIMEOUT - 1))) begin
               state_nxt = WAIT_DONE;
            end
         end
         WAIT_DONE: begin
            if (!is_transmitting) begin
               ptr_nxt   = grant_id + 1'b1;
               state_nxt = IDLE;
            end
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

   // State and registered outputs with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         ptr       <= '0;
         cnt       <= 8'd0;
         req_ready <= '0;
         transmit  <= 1'b0;
         tx_byte   <= 8'h00;
         grant_id  <= '0;
`ifdef UART_ARB_LOCK_EN
         locked    <= 1'b0;
`endif
      end else begin
         state     <= state_nxt;
         ptr       <= ptr_nxt;
         cnt       <= cnt_nxt;
         req_ready <= ready_nxt;
         transmit  <= transmit_nxt;
         tx_byte   <= byte_nxt;
         grant_id  <= grant_nxt;
`ifdef UART_ARB_LOCK_EN
         locked    <= locked_nxt;
`endif
      end
   end

endmodule

// File: doc/uart_tx_arbiter.md
# uart_tx_arbiter

Round-robin arbiter that shares one `uart` transmitter between `NUM_REQ` byte producers (greeting sequencer, debug echo, status reporters). It accepts one byte per grant over a valid/ready handshake and pulses the UART `transmit`/`tx_byte` inputs. It then tracks `is_transmitting` until the frame completes before granting again. It sits between the producers and the `uart` instance in the board top level.

## Interface

- `NUM_REQ`, 4: number of requesters; power of two, 2..8.
- `WAIT_TIMEOUT`, 16: cycles to wait for `is_transmitting` to rise after a `transmit` pulse before the byte is treated as started; range 1..255.

- `clk`  in  1  system clock; one clock, all logic on rising edge.
- `rst`  in  1  reset; synchronous and active-high.
- `req_valid`  in  NUM_REQ  requester i has a byte.
- `req_data`  in  8*NUM_REQ  byte of requester i in bits [8i+7:8i].
- `req_last`  in  NUM_REQ  byte ends a packet; used only with lock mode.
- `req_ready`  out  NUM_REQ  one-hot, one-cycle accept strobe.
- `grant_id`  out  $clog2(NUM_REQ)  index of the current or last granted requester.
- `busy`  out  1  high whenever the state is not IDLE.
- `transmit`  out  1  to uart `transmit`; one-cycle pulse.
- `tx_byte`  out  8  to uart `tx_byte`; held until the next load.
- `is_transmitting`  in  1  from uart.

## Operation

- States: IDLE, LOAD, START, WAIT_BUSY, WAIT_DONE.
- IDLE:
  - Requires `is_transmitting`=0.
  - Scans `req_valid` starting at `ptr`, wrapping modulo NUM_REQ.
  - On the first valid requester: `grant_id`<=winner, `req_ready`<=onehot(winner), go to LOAD.
  - If none is valid, stay in IDLE.
- LOAD: `req_ready` is high this cycle and the transfer occurs.
  - If `req_valid[grant_id]`=1: `tx_byte`<=its data, `transmit`<=1, `req_ready`<=0, go to START.
  - If `req_valid[grant_id]`=0 (withdrawn): `req_ready`<=0, return to IDLE. No transmit occurs and `ptr` is unchanged.
- START: `transmit`=1 for this cycle only. Then `transmit`<=0, clear the timeout counter, go to WAIT_BUSY.
- WAIT_BUSY: increment the counter each cycle.
  - Go to WAIT_DONE when `is_transmitting`=1, or when the counter reaches WAIT_TIMEOUT.
- WAIT_DONE: on `is_transmitting`=0, set `ptr`<=grant_id+1 (wrapping) and go to IDLE.
- Requesters hold `req_valid` and `req_data` stable from assertion until `req_ready`.
- Fairness: each requester waits at most NUM_REQ-1 bytes from others.
- Reset values:
  - state IDLE, `ptr`=0, counter 0.
  - `req_ready`=0, `transmit`=0, `tx_byte`=8'h00, `grant_id`=0, `busy`=0.
  - A reset mid-frame abandons the byte. The UART finishes that frame independently, and the arbiter will not grant again until `is_transmitting`=0.

## Timing

- Valid seen in IDLE at cycle 0 -> `req_ready` at cycle 1 -> `transmit` at cycle 2.
- Next grant no earlier than the cycle after `is_transmitting` falls.
- Minimum period per byte is 4 cycles plus the UART frame time.
- All outputs are registered; no combinational path from inputs to outputs.
- `busy` is decoded from the state register.

## Configuration

- `UART_ARB_LOCK_EN` defined:
  - After accepting a byte with `req_last`=0, the grant is locked to that requester. IDLE considers only that requester, even when others are valid.
  - The lock is released after a byte with `req_last`=1 is accepted; `ptr` then advances normally.
  - The lock is cleared by `rst`.
- `UART_ARB_LOCK_EN` undefined:
  - `req_last` is ignored; arbitration is per byte.
  - No lock register is synthesized.

## Test plan

- Reset, then req0 valid with 8'h48, UART model raises busy 2 cycles after `transmit` and holds it 100 cycles -> `req_ready`=4'b0001 at cycle 1, `transmit` with `tx_byte`=8'h48 at cycle 2, `busy` low 1 cycle after `is_transmitting` falls.
- All four requesters valid continuously with bytes 8'hA0..8'hA3 -> transmit order A0,A1,A2,A3,A0; `grant_id` 0,1,2,3,0.
- `is_transmitting` never rises, `WAIT_TIMEOUT`=16 -> WAIT_BUSY exits 16 cycles after START, arbiter returns to IDLE, and the next byte is granted.
- req2 drops `req_valid` during LOAD -> no `transmit`, `ptr` unchanged; req2 reasserts and is granted next.
- Reset asserted in WAIT_DONE with `is_transmitting`=1 -> all outputs zero the next cycle; no `req_ready` until `is_transmitting`=0.
- With `UART_ARB_LOCK_EN`: req1 sends 3 bytes with `req_last`=0,0,1 while req0 is valid -> the three req1 bytes go out consecutively, then req0 is granted.
